ioctl_word_loader: RTL and testbench

Parametrised ROM-download bridge between the host ioctl byte stream and a core's wide ROM/SDRAM write port.
- Assembles little-endian bytes into DATA_WIDTH words and buffers them in a small FIFO.
- Drives a valid/ready write interface and back-pressures the host through ioctl_wait, which the simulation top currently ties to 0.
- Sits between the top-level ioctl pins and the core's ROM loader.

---
 rtl/m72_loader_pkg.sv | 22 ++
 rtl/ioctl_word_loader_if.sv | 18 +
 rtl/loader_fifo.sv | 52 +++++
 rtl/ioctl_word_loader.sv | 160 ++++++++++++++++
 tb/tb_ioctl_word_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m72_loader_pkg.sv
// Shared types and constants for the M72 ROM download path.
package m72_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } loader_state_t;

    // ioctl_index values used by the host for each ROM region
    localparam logic [7:0] IDX_ROM_MAIN   = 8'h00;
    localparam logic [7:0] IDX_ROM_SOUND  = 8'h01;
    localparam logic [7:0] IDX_ROM_SPRITE = 8'h02;
    localparam logic [7:0] IDX_ROM_TILE   = 8'h03;

    // Number of byte-address bits that select a lane inside one word
    function automatic int lane_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ioctl_word_loader_if.sv
// Word write port from the loader to the core's ROM/SDRAM writer.
interface ioctl_word_loader_if
    import m72_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 25
);
    localparam int LB = lane_bits(DATA_WIDTH);

    logic [ADDR_WIDTH-LB-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     wr_valid;
    logic                     wr_ready;

    modport master (output wr_addr, output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_addr, input wr_data, input wr_valid, output wr_ready);

endinterface

// File: rtl/loader_fifo.sv
// Small synchronous FIFO holding {word address, word} pairs.
module loader_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 24,
    parameter int DEPTH      = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [ADDR_WIDTH-1:0]      push_addr,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [ADDR_WIDTH-1:0]      head_addr,
    output logic [DATA_WIDTH-1:0]      head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] count_next,
    output logic                       dropped
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic full, do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A push into a full FIFO still fits when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign {head_addr, head_data} = mem[rd_ptr];

    // Storage write; contents need no reset since count gates the output
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= {push_addr, push_data};
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

endmodule

// File: rtl/ioctl_word_loader.sv
// Bridges the host ioctl byte stream to a wide ROM write port.
module ioctl_word_loader
    import m72_loader_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter int         ADDR_WIDTH = 25,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] ROM_INDEX  = IDX_ROM_MAIN,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [ADDR_WIDTH-1:0] ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    input  logic [7:0]            ioctl_index,
    output logic                  ioctl_wait,
    ioctl_word_loader_if.master   wr,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int LB  = lane_bits(DATA_WIDTH);
    localparam int NL  = DATA_WIDTH / 8;
    localparam int LBW = (LB == 0) ? 1 : LB;
    localparam int WAW = ADDR_WIDTH - LB;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] FILL_WORD = {NL{FILL_BYTE}};

    loader_state_t state, state_next;

    logic                  dl_q;
    logic [DATA_WIDTH-1:0] asm_q, asm_ins;
    logic [NL-1:0]         mask_q;
    logic [ADDR_WIDTH-1:0] exp_addr_q;
    logic [WAW-1:0]        last_waddr_q, waddr;
    logic [LBW-1:0]        lane;
    logic                  push_q;
    logic [WAW-1:0]        push_addr_q, head_addr;
    logic [DATA_WIDTH-1:0] push_data_q, head_data;
    logic                  enter_load, accept, complete, flush_partial;
    logic [CW-1:0]         count, count_next;
    logic                  dropped, pop;

    assign enter_load    = (state_next == ST_LOAD) && (state != ST_LOAD);
    assign accept        = (state == ST_LOAD) && ioctl_wr && (ioctl_index == ROM_INDEX);
    assign lane          = (LB == 0) ? '0 : ioctl_addr[LBW-1:0];
    assign waddr         = ioctl_addr[ADDR_WIDTH-1:LB];
    assign complete      = accept && (lane == LBW'(NL - 1));
    assign flush_partial = (state == ST_FLUSH) && (mask_q != '0);

    assign busy = (state == ST_LOAD) || (state == ST_FLUSH);
    assign done = (state == ST_DONE);

    assign wr.wr_valid = (count != '0);
    assign wr.wr_addr  = wr.wr_valid ? head_addr : '0;
    assign wr.wr_data  = wr.wr_valid ? head_data : '0;
    assign pop         = wr.wr_valid && wr.wr_ready;

    // Assembly register with the incoming byte dropped into its lane
    always_comb begin
        asm_ins = asm_q;
        for (int unsigned i = 0; i < NL; i++) begin
            if (lane == LBW'(i)) asm_ins[i*8 +: 8] = ioctl_dout;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE:
                if (ioctl_download && !dl_q && (ioctl_index == ROM_INDEX)) state_next = ST_LOAD;
            ST_LOAD:
                if (!ioctl_download) state_next = ST_FLUSH;
            ST_FLUSH:
                if ((mask_q == '0) && !push_q && (count == '0)) state_next = ST_DONE;
            default:
                state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Byte assembly, address tracking and the one-cycle push stage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dl_q         <= 1'b0;
            asm_q        <= FILL_WORD;
            mask_q       <= '0;
            exp_addr_q   <= '0;
            last_waddr_q <= '0;
            push_q       <= 1'b0;
            push_addr_q  <= '0;
            push_data_q  <= '0;
            error        <= 1'b0;
        end else begin
            dl_q   <= ioctl_download;
            push_q <= complete || flush_partial;
            if (enter_load) begin
                asm_q      <= FILL_WORD;
                mask_q     <= '0;
                exp_addr_q <= '0;
                error      <= 1'b0;
            end else begin
                if (accept) begin
                    exp_addr_q   <= ioctl_addr + 1'b1;
                    last_waddr_q <= waddr;
                    if (ioctl_addr != exp_addr_q) error <= 1'b1;
                    if (complete) begin
                        asm_q       <= FILL_WORD;
                        mask_q      <= '0;
                        push_addr_q <= waddr;
                        push_data_q <= asm_ins;
                    end else begin
                        asm_q        <= asm_ins;
                        mask_q[lane] <= 1'b1;
                    end
                end else if (flush_partial) begin
                    // No byte can arrive in FLUSH, so the partial word is final here
                    asm_q       <= FILL_WORD;
                    mask_q      <= '0;
                    push_addr_q <= last_waddr_q;
                    push_data_q <= asm_q;
                end
                if (dropped) error <= 1'b1;
            end
        end
    end

    // Host stall request, looking one cycle ahead at FIFO occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ioctl_wait <= 1'b0;
        else          ioctl_wait <= (count_next >= CW'(FIFO_DEPTH - 1)) || (state_next == ST_FLUSH);
    end

    loader_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (WAW),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push_q),
        .push_addr  (push_addr_q),
        .push_data  (push_data_q),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .count_next (count_next),
        .dropped    (dropped)
    );

endmodule

// File: tb/tb_ioctl_word_loader.sv
// Randomised bench for ioctl_word_loader at 16- and 32-bit word widths.
`timescale 1ns/1ps
module tb_ioctl_word_loader;
    localparam int AW = 25;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n;
    logic          dl16, dl32, ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout, ioctl_index;
    logic          wait16, wait32, busy16, busy32, done16, done32, err16, err32;
    logic          rmode16, rmode32, rdy16, rdy32, rnd16, rnd32;

    ioctl_word_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(AW)) if16 ();
    ioctl_word_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) if32 ();

    assign if16.wr_ready = rmode16 ? rnd16 : rdy16;
    assign if32.wr_ready = rmode32 ? rnd32 : rdy32;

    ioctl_word_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(AW), .FIFO_DEPTH(4),
                        .ROM_INDEX(8'h00), .FILL_BYTE(8'hFF)) u16 (
        .clock(clock), .reset_n(reset_n), .ioctl_download(dl16), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(wait16), .wr(if16), .busy(busy16), .done(done16), .error(err16));

    ioctl_word_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .FIFO_DEPTH(4),
                        .ROM_INDEX(8'h00), .FILL_BYTE(8'hFF)) u32 (
        .clock(clock), .reset_n(reset_n), .ioctl_download(dl32), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(wait32), .wr(if32), .busy(busy32), .done(done32), .error(err32));

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned sel = 0;                 // 0: 16-bit instance, 1: 32-bit instance

    int unsigned  sent_a[$];
    logic [7:0]   sent_d[$];
    logic [31:0]  cap16_a[$], cap32_a[$], exp_a[$];
    logic [63:0]  cap16_d[$], cap32_d[$], exp_d[$];
    logic         exp_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_wait();
        return (sel == 0) ? wait16 : wait32;
    endfunction

    function automatic logic cur_done();
        return (sel == 0) ? done16 : done32;
    endfunction

    function automatic logic cur_err();
        return (sel == 0) ? err16 : err32;
    endfunction

    // Random sink readiness, changed just after each active edge
    initial begin
        rnd16 = 1'b1;
        rnd32 = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            rnd16 = 1'($urandom_range(0, 1));
            rnd32 = 1'($urandom_range(0, 1));
        end
    end

    // Write-port monitor: capture accepted words and check hold stability
    logic        hold16 = 1'b0, hold32 = 1'b0;
    logic [31:0] ha16, ha32;
    logic [63:0] hd16, hd32;
    always @(negedge clock) begin
        if (hold16 && if16.wr_valid) begin
            check_val("hold16_addr", 64'(if16.wr_addr), 64'(ha16));
            check_val("hold16_data", 64'(if16.wr_data), hd16);
        end
        if (hold32 && if32.wr_valid) begin
            check_val("hold32_addr", 64'(if32.wr_addr), 64'(ha32));
            check_val("hold32_data", 64'(if32.wr_data), hd32);
        end
        hold16 = if16.wr_valid && !if16.wr_ready;
        hold32 = if32.wr_valid && !if32.wr_ready;
        ha16 = 32'(if16.wr_addr); hd16 = 64'(if16.wr_data);
        ha32 = 32'(if32.wr_addr); hd32 = 64'(if32.wr_data);
        if (if16.wr_valid && if16.wr_ready) begin
            cap16_a.push_back(32'(if16.wr_addr));
            cap16_d.push_back(64'(if16.wr_data));
        end
        if (if32.wr_valid && if32.wr_ready) begin
            cap32_a.push_back(32'(if32.wr_addr));
            cap32_d.push_back(64'(if32.wr_data));
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input int unsigned a, input logic [7:0] d, input bit obey);
        int unsigned n = 0;
        if (obey) begin
            while (cur_wait() && n < 400) begin
                cycles(1);
                n++;
            end
            check_val("host_wait_bound", 64'(n >= 400), 64'd0);
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = AW'(a);
        ioctl_dout = d;
        sent_a.push_back(a);
        sent_d.push_back(d);
        cycles(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        sent_a.delete();
        sent_d.delete();
        if (sel == 0) begin cap16_a.delete(); cap16_d.delete(); dl16 = 1'b1; end
        else          begin cap32_a.delete(); cap32_d.delete(); dl32 = 1'b1; end
        ioctl_index = 8'h00;
        cycles(2);
    endtask

    task automatic end_dl();
        int unsigned n = 0;
        if (sel == 0) dl16 = 1'b0;
        else          dl32 = 1'b0;
        do begin
            cycles(1);
            n++;
        end while (!cur_done() && n < 1000);
        check_val("done_bound", 64'(n >= 1000), 64'd0);
        cycles(2);
    endtask

    // Reference: each byte lands in lane addr%nb; a word leaves when its top
    // lane is written, and any leftover lanes leave at the end with fill bytes.
    task automatic build_model(input int unsigned nb);
        logic [63:0] fillw, w;
        int unsigned expa, lasta, lane;
        bit          pending;
        fillw = (64'd1 << (nb * 8)) - 64'd1;
        w = fillw;
        expa = 0; lasta = 0; pending = 0; exp_err = 1'b0;
        exp_a.delete();
        exp_d.delete();
        foreach (sent_a[k]) begin
            lane = sent_a[k] % nb;
            if (sent_a[k] != expa) exp_err = 1'b1;
            expa  = sent_a[k] + 1;
            lasta = sent_a[k];
            w[lane*8 +: 8] = sent_d[k];
            pending = 1;
            if (lane == nb - 1) begin
                exp_a.push_back(32'(sent_a[k] / nb));
                exp_d.push_back(w);
                w = fillw;
                pending = 0;
            end
        end
        if (pending) begin
            exp_a.push_back(32'(lasta / nb));
            exp_d.push_back(w);
        end
    endtask

    task automatic compare_words(input string tag);
        logic [31:0] ca[$];
        logic [63:0] cd[$];
        if (sel == 0) begin ca = cap16_a; cd = cap16_d; end
        else          begin ca = cap32_a; cd = cap32_d; end
        check_val($sformatf("%s_count", tag), 64'(ca.size()), 64'(exp_a.size()));
        for (int unsigned i = 0; i < exp_a.size() && i < ca.size(); i++) begin
            check_val($sformatf("%s_w%0d_addr", tag, i), 64'(ca[i]), 64'(exp_a[i]));
            check_val($sformatf("%s_w%0d_data", tag, i), cd[i], exp_d[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        dl16 = 1'b0; dl32 = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = 8'h00;
        rmode16 = 1'b0; rmode32 = 1'b0; rdy16 = 1'b1; rdy32 = 1'b1;
        cycles(3);
        check_val("rst_valid16", 64'(if16.wr_valid), 0);
        check_val("rst_busy16", 64'(busy16), 0);
        check_val("rst_done16", 64'(done16), 0);
        check_val("rst_wait32", 64'(wait32), 0);
        check_val("rst_err32", 64'(err32), 0);
        reset_n = 1'b1;
        cycles(2);

        // Basic 16-bit download with the N+2 valid latency
        sel = 0;
        start_dl();
        send_byte(0, 8'h11, 1);
        check_val("t1_valid_n1", 64'(if16.wr_valid), 0);
        send_byte(1, 8'h22, 1);
        check_val("t1_valid_n1b", 64'(if16.wr_valid), 0);
        cycles(1);
        check_val("t1_valid_n2", 64'(if16.wr_valid), 1);
        send_byte(2, 8'h33, 1);
        send_byte(3, 8'h44, 1);
        end_dl();
        build_model(2);
        compare_words("t1");
        if (cap16_d.size() >= 2) begin
            check_val("t1_word0", cap16_d[0], 64'h2211);
            check_val("t1_word1", cap16_d[1], 64'h4433);
        end
        check_val("t1_done", 64'(done16), 1);
        check_val("t1_error", 64'(err16), 0);

        // 32-bit download ending on a partial word
        sel = 1;
        start_dl();
        for (int unsigned i = 0; i < 5; i++) send_byte(i, 8'(i + 1), 1);
        end_dl();
        build_model(4);
        compare_words("t2");
        if (cap32_d.size() >= 2) begin
            check_val("t2_word0", cap32_d[0], 64'h04030201);
            check_val("t2_word1", cap32_d[1], 64'hFFFFFF05);
        end

        // Back-pressure: host honours ioctl_wait, one in-flight byte allowed
        sel = 0;
        start_dl();
        rdy16 = 1'b0;
        fork
            for (int unsigned i = 0; i < 8; i++) send_byte(i, 8'($urandom), 1);
            begin
                cycles(20);
                check_val("t3_wait_high", 64'(wait16), 1);
                check_val("t3_bytes_at_stall", 64'(sent_a.size()), 7);
                check_val("t3_no_pop", 64'(cap16_a.size()), 0);
                rdy16 = 1'b1;
            end
        join
        end_dl();
        build_model(2);
        compare_words("t3");
        check_val("t3_wait_low", 64'(wait16), 0);
        check_val("t3_error", 64'(err16), 0);

        // Overflow: ignore ioctl_wait and push a fifth word into a full FIFO
        start_dl();
        rdy16 = 1'b0;
        for (int unsigned i = 0; i < 10; i++) send_byte(i, 8'($urandom), 0);
        cycles(2);
        check_val("t4_error_set", 64'(err16), 1);
        rdy16 = 1'b1;
        end_dl();
        build_model(2);
        while (exp_a.size() > 4) begin
            void'(exp_a.pop_back());
            void'(exp_d.pop_back());
        end
        compare_words("t4");
        check_val("t4_error_sticky", 64'(err16), 1);

        // Address discontinuity 0,1,3
        start_dl();
        send_byte(0, 8'hA0, 1);
        send_byte(1, 8'hA1, 1);
        check_val("t5_error_before", 64'(err16), 0);
        send_byte(3, 8'hA3, 1);
        check_val("t5_error_after", 64'(err16), 1);
        end_dl();
        build_model(2);
        compare_words("t5");
        if (cap16_d.size() >= 2) check_val("t5_word1", cap16_d[1], 64'hA3FF);
        check_val("t5_error_model", 64'(err16), 64'(exp_err));

        // Reset in the middle of a download with two words queued
        start_dl();
        rdy16 = 1'b0;
        for (int unsigned i = 0; i < 4; i++) send_byte(i, 8'($urandom), 1);
        cycles(3);
        check_val("t6_queued", 64'(if16.wr_valid), 1);
        #1;
        reset_n = 1'b0;
        dl16 = 1'b0;
        #1;
        check_val("t6_valid", 64'(if16.wr_valid), 0);
        check_val("t6_busy", 64'(busy16), 0);
        check_val("t6_done", 64'(done16), 0);
        check_val("t6_wait", 64'(wait16), 0);
        cycles(1);
        reset_n = 1'b1;
        rdy16 = 1'b1;
        cycles(1);
        start_dl();
        for (int unsigned i = 0; i < 6; i++) send_byte(i, 8'($urandom), 1);
        end_dl();
        build_model(2);
        compare_words("t6");
        check_val("t6_error", 64'(err16), 0);

        // Foreign ioctl_index traffic is ignored
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
        cycles(1);
        cap16_a.delete();
        cap16_d.delete();
        ioctl_index = 8'h01;
        dl16 = 1'b1;
        cycles(2);
        check_val("t7_busy_load", 64'(busy16), 0);
        for (int unsigned i = 0; i < 6; i++) send_byte(i, 8'($urandom), 0);
        dl16 = 1'b0;
        cycles(10);
        check_val("t7_writes", 64'(cap16_a.size()), 0);
        check_val("t7_busy", 64'(busy16), 0);
        check_val("t7_done", 64'(done16), 0);
        ioctl_index = 8'h00;

        // Random downloads on both widths with random sink readiness
        for (int unsigned r = 0; r < 12; r++) begin
            int unsigned a, nbytes;
            sel = r % 2;
            rmode16 = (sel == 0);
            rmode32 = (sel == 1);
            start_dl();
            nbytes = $urandom_range(1, 24);
            a = 0;
            for (int unsigned i = 0; i < nbytes; i++) begin
                if ($urandom_range(0, 15) == 0) a += $urandom_range(1, 3);
                send_byte(a, 8'($urandom), 1);
                a++;
                cycles($urandom_range(0, 2));
            end
            end_dl();
            build_model((sel == 0) ? 2 : 4);
            compare_words($sformatf("rnd%0d", r));
            check_val($sformatf("rnd%0d_error", r), 64'(cur_err()), 64'(exp_err));
            rmode16 = 1'b0;
            rmode32 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
